// File: rtl/cnn_conv_pkg.sv
// -----------------------------------------------------------------------------
// cnn_conv_pkg
// Shared definitions for the K x K convolution engine and the CNN16 datapath:
//   - state_e      : engine FSM state encoding
//   - acc_width()  : accumulator width needed for K*K products without overflow
//   - shift_sat()  : arithmetic right shift by the fraction width followed by
//                    saturation to a signed data_w-bit range
// -----------------------------------------------------------------------------
package cnn_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_PIX = 3'd1,
    ST_RD_KER = 3'd2,
    ST_MAC    = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Product is 2*data_w bits; summing k*k of them needs clog2(k*k) guard bits.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned k);
    return 2 * data_w + $clog2(k * k);
  endfunction

  // Operates on a 128-bit sign-extended accumulator so one function serves any
  // accumulator width; callers truncate the result to data_w bits, which is
  // lossless because the value is already clamped to that range.
  function automatic logic signed [63:0] shift_sat(input logic signed [127:0] acc,
                                                   input int unsigned         frac,
                                                   input int unsigned         data_w);
    logic signed [127:0] shifted;
    logic signed [127:0] max_v;
    logic signed [127:0] min_v;
    logic signed [63:0]  res;
    shifted = acc >>> frac;
    max_v   = (128'sd1 <<< (data_w - 32'd1)) - 128'sd1;
    min_v   = -max_v - 128'sd1;
    if (shifted > max_v) begin
      res = max_v[63:0];
    end else if (shifted < min_v) begin
      res = min_v[63:0];
    end else begin
      res = shifted[63:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/cnn_conv_mac.sv
// -----------------------------------------------------------------------------
// cnn_conv_mac
// Signed multiply-accumulate with clear/enable and the output
// shift/saturate stage. Optional macro CNN_CONV_RELU_EN clamps negative
// saturated results to zero.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : clear accumulator (new operation accepted)
//   en_i       : accumulate pix_i*ker_i this cycle
//   pix_i      : signed pixel operand
//   ker_i      : signed weight operand
//   sat_o      : shifted/saturated value of the accumulator *including* this
//                cycle's product, so the caller can latch it on the last tap
// -----------------------------------------------------------------------------
module cnn_conv_mac
  import cnn_conv_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned K      = 3,
  parameter int unsigned FRAC   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] pix_i,
  input  logic signed [DATA_W-1:0] ker_i,
  output logic signed [DATA_W-1:0] sat_o
);

  localparam int unsigned ACC_W = acc_width(DATA_W, K);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [DATA_W-1:0]   sat_s;

  // Full-precision product and next accumulator value.
  always_comb begin
    prod_s = (2*DATA_W)'(pix_i) * (2*DATA_W)'(ker_i);
    acc_d  = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod_s);
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Output stage: shift, saturate, optional ReLU.
  always_comb begin
    sat_s = DATA_W'(shift_sat(128'(acc_d), FRAC, DATA_W));
`ifdef CNN_CONV_RELU_EN
    if (sat_s[DATA_W-1]) begin
      sat_o = '0;
    end else begin
      sat_o = sat_s;
    end
`else
    sat_o = sat_s;
`endif
  end

endmodule

// File: rtl/cnn_conv_engine.sv
// -----------------------------------------------------------------------------
// cnn_conv_engine
// K x K convolution engine: fetches K*K pixels and weights over a single-port
// memory handshake, accumulates in cnn_conv_mac, writes the shifted/saturated
// result to out_addr and pulses done. Optional macro: CNN_CONV_RELU_EN.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : launch request (honoured only in IDLE)
//   img_base, ker_base, out_addr: window / kernel / result addresses
//   busy, done, result          : status and last written value
//   mem_req, mem_we, address,
//   to_memory                   : registered memory request
//   from_memory, mem_ready      : memory response
// -----------------------------------------------------------------------------
module cnn_conv_engine
  import cnn_conv_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned K      = 3,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned FRAC   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] img_base,
  input  logic [ADDR_W-1:0] ker_base,
  input  logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] to_memory,
  input  logic [DATA_W-1:0] from_memory,
  input  logic              mem_ready
);

  localparam int unsigned    CW   = 3;
  localparam logic [CW-1:0]  LAST = CW'(K - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     r_q, r_d, c_q, c_d;
  logic [CW-1:0]     r_n_s, c_n_s;
  logic [ADDR_W-1:0] img_base_q, img_base_d;
  logic [ADDR_W-1:0] ker_base_q, ker_base_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] pix_q, pix_d, ker_q, ker_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] to_memory_q, to_memory_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              clr_s, en_s;
  logic [DATA_W-1:0] sat_s;

  // base + r*stride + c, wrapping modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [CW-1:0]     r,
                                                 input logic [CW-1:0]     c,
                                                 input int unsigned       stride);
    return base + ADDR_W'(r) * ADDR_W'(stride) + ADDR_W'(c);
  endfunction

  cnn_conv_mac #(
    .DATA_W (DATA_W),
    .K      (K),
    .FRAC   (FRAC)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (clr_s),
    .en_i  (en_s),
    .pix_i (pix_q),
    .ker_i (ker_q),
    .sat_o (sat_s)
  );

  // Row-major successor of the current tap.
  always_comb begin
    if (c_q == LAST) begin
      c_n_s = '0;
      r_n_s = r_q + 3'd1;
    end else begin
      c_n_s = c_q + 3'd1;
      r_n_s = r_q;
    end
  end

  // FSM next state, handshake and datapath control.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    c_d         = c_q;
    img_base_d  = img_base_q;
    ker_base_d  = ker_base_q;
    out_addr_d  = out_addr_q;
    pix_d       = pix_q;
    ker_d       = ker_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    address_d   = address_q;
    to_memory_d = to_memory_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    clr_s       = 1'b0;
    en_s        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RD_PIX;
          img_base_d = img_base;
          ker_base_d = ker_base;
          out_addr_d = out_addr;
          r_d        = '0;
          c_d        = '0;
          clr_s      = 1'b1;
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          address_d  = img_base;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_RD_PIX: begin
        // Request stays high into RD_KER; only the address moves.
        if (mem_ready) begin
          pix_d     = from_memory;
          state_d   = ST_RD_KER;
          address_d = tap_addr(ker_base_q, r_q, c_q, K);
        end else begin
          state_d = ST_RD_PIX;
        end
      end
      ST_RD_KER: begin
        if (mem_ready) begin
          ker_d     = from_memory;
          state_d   = ST_MAC;
          mem_req_d = 1'b0;
        end else begin
          state_d = ST_RD_KER;
        end
      end
      ST_MAC: begin
        en_s      = 1'b1;
        mem_req_d = 1'b1;
        if ((r_q == LAST) && (c_q == LAST)) begin
          // sat_s already includes this cycle's product.
          state_d     = ST_WRITE;
          mem_we_d    = 1'b1;
          address_d   = out_addr_q;
          to_memory_d = sat_s;
        end else begin
          state_d   = ST_RD_PIX;
          r_d       = r_n_s;
          c_d       = c_n_s;
          address_d = tap_addr(img_base_q, r_n_s, c_n_s, IMG_W);
        end
      end
      ST_WRITE: begin
        if (mem_ready) begin
          result_d  = to_memory_q;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = ST_DONE;
          done_d    = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      c_q         <= '0;
      img_base_q  <= '0;
      ker_base_q  <= '0;
      out_addr_q  <= '0;
      pix_q       <= '0;
      ker_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      address_q   <= '0;
      to_memory_q <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      c_q         <= c_d;
      img_base_q  <= img_base_d;
      ker_base_q  <= ker_base_d;
      out_addr_q  <= out_addr_d;
      pix_q       <= pix_d;
      ker_q       <= ker_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      address_q   <= address_d;
      to_memory_q <= to_memory_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign address   = address_q;
  assign to_memory = to_memory_q;

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Self-checking bench for cnn_conv_engine (K=3, IMG_W=8, FRAC=8).
module tb_cnn_conv_engine;

  localparam logic [11:0] KB = 12'h100;
  localparam logic [11:0] OA = 12'h800;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] img_base, ker_base, out_addr, address;
  logic        busy, done, mem_req, mem_we, mem_ready;
  logic [15:0] result, to_memory, from_memory;

  logic [15:0] mem [0:4095];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_n = 0;
  int wait_cnt = 0;

  logic [11:0] exp_addr_q[$];
  logic [15:0] exp_res_q[$];
  logic        prev_req = 1'b0, prev_ready = 1'b1, prev_we = 1'b0;
  logic [11:0] prev_addr = 12'h000;
  logic [15:0] prev_data = 16'h0000;
  logic [15:0] mon_e;
  logic [11:0] mon_a;

  typedef struct {
    logic [11:0] ib;
    logic [15:0] pix, cpix, ker, cker;
    int          stall;
    logic [15:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  assign from_memory = mem[address];
  assign mem_ready   = (wait_cnt >= stall_n);

  cnn_conv_engine dut (
    .clk(clk), .rst(rst), .start(start),
    .img_base(img_base), .ker_base(ker_base), .out_addr(out_addr),
    .busy(busy), .done(done), .result(result),
    .mem_req(mem_req), .mem_we(mem_we), .address(address),
    .to_memory(to_memory), .from_memory(from_memory), .mem_ready(mem_ready)
  );

  // Cycle counter and wait-state generator.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_req && mem_ready) wait_cnt <= 0;
    else if (mem_req)         wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory-side monitor: scoreboard for reads/writes, stability during stalls.
  always @(negedge clk) begin
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        check("pending_write", 32'(exp_res_q.size() != 0), 32'd1);
        if (exp_res_q.size() != 0) begin
          mon_e = exp_res_q.pop_front();
          check("write_data", 32'(to_memory), 32'(mon_e));
          check("write_addr", 32'(address), 32'(OA));
        end
      end else begin
        check("pending_read", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) begin
          mon_a = exp_addr_q.pop_front();
          check("read_addr", 32'(address), 32'(mon_a));
        end
      end
    end
    if (mem_req && prev_req && !prev_ready) begin
      check("stall_addr", 32'(address), 32'(prev_addr));
      check("stall_we", 32'(mem_we), 32'(prev_we));
      check("stall_data", 32'(to_memory), 32'(prev_data));
    end
    prev_req   = mem_req;
    prev_ready = mem_ready;
    prev_we    = mem_we;
    prev_addr  = address;
    prev_data  = to_memory;
  end

  task automatic load_mem(input logic [11:0] ib, input logic [15:0] pix, input logic [15:0] cpix,
                          input logic [15:0] ker, input logic [15:0] cker);
    logic [11:0] a;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = ib + 12'(r * 8 + c);
        mem[a] = (r == 1 && c == 1) ? cpix : pix;
        a = KB + 12'(r * 3 + c);
        mem[a] = (r == 1 && c == 1) ? cker : ker;
      end
  endtask

  task automatic load_rand(input logic [11:0] ib);
    logic [11:0] a;
    logic signed [4:0] k5;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = ib + 12'(r * 8 + c);
        mem[a] = 16'($urandom);
        a = KB + 12'(r * 3 + c);
        k5 = 5'($urandom);
        mem[a] = 16'(k5);
      end
  endtask

  task automatic push_addrs(input logic [11:0] ib);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        exp_addr_q.push_back(ib + 12'(r * 8 + c));
        exp_addr_q.push_back(KB + 12'(r * 3 + c));
      end
  endtask

  function automatic logic [15:0] model(input logic [11:0] ib);
    longint acc;
    longint sh;
    logic [11:0] a, b;
    acc = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = ib + 12'(r * 8 + c);
        b = KB + 12'(r * 3 + c);
        acc += longint'($signed(mem[a])) * longint'($signed(mem[b]));
      end
    sh = acc >>> 8;
    if (sh > 32767) sh = 32767;
    else if (sh < -32768) sh = -32768;
`ifdef CNN_CONV_RELU_EN
    if (sh < 0) sh = 0;
`endif
    return 16'(sh);
  endfunction

  task automatic run_one(input logic [11:0] ib, input int stall, input logic [15:0] exp,
                         input int lat, input bit stray);
    int t0;
    int lat_seen;
    bit got;
    stall_n = stall;
    push_addrs(ib);
    exp_res_q.push_back(exp);
    @(negedge clk);
    img_base = ib; ker_base = KB; out_addr = OA; start = 1'b1; t0 = cyc;
    got = 1'b0; lat_seen = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      start = (stray && i == 5);
      if (stray && i == 5) begin
        img_base = 12'h400; out_addr = 12'h123;
      end
      if (i == 1) check("busy_run", 32'(busy), 32'd1);
      if (done) begin
        got = 1'b1; lat_seen = cyc - t0;
        break;
      end
    end
    start = 1'b0;
    check("done_seen", 32'(got), 32'd1);
    check("done_latency", 32'(lat_seen), 32'(lat));
    check("result", 32'(result), 32'(exp));
    check("queues_empty", 32'(exp_res_q.size() + exp_addr_q.size()), 32'd0);
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [15:0] e;
    int t0;
    rst = 1'b1; start = 1'b0; img_base = 12'h000; ker_base = KB; out_addr = OA;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

    vecs[0] = '{12'h010, 16'h1234, 16'h0300, 16'h0000, 16'h0100, 0, 16'h0300, 29};
    vecs[1] = '{12'h010, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 16'h7FFF, 29};
`ifdef CNN_CONV_RELU_EN
    vecs[2] = '{12'h010, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 0, 16'h0000, 29};
    vecs[3] = '{12'h010, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 0, 16'h0000, 29};
`else
    vecs[2] = '{12'h010, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 0, 16'h8000, 29};
    vecs[3] = '{12'h010, 16'h0100, 16'h0100, 16'hFF00, 16'hFF00, 0, 16'hF700, 29};
`endif
    vecs[4] = '{12'h030, 16'h1234, 16'h0300, 16'h0000, 16'h0100, 2, 16'h0300, 67};
    vecs[5] = '{12'hFFE, 16'h0200, 16'h0200, 16'h0080, 16'h0080, 0, 16'h0900, 29};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_to_memory", 32'(to_memory), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      load_mem(vecs[v].ib, vecs[v].pix, vecs[v].cpix, vecs[v].ker, vecs[v].cker);
      run_one(vecs[v].ib, vecs[v].stall, vecs[v].exp, vecs[v].lat, 1'b0);
    end

    // Abort during RD_KER of tap 4 (cycle T+14 with zero wait states).
    stall_n = 0;
    load_rand(12'h020);
    push_addrs(12'h020);
    @(negedge clk);
    img_base = 12'h020; out_addr = OA; start = 1'b1; t0 = cyc;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_address", 32'(address), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    exp_addr_q.delete();
    exp_res_q.delete();

    // Fresh run after abort, with a stray start while busy.
    e = model(12'h020);
    run_one(12'h020, 0, e, 29, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
